// File: rtl/mux_scan_nw.sv
// rtl/mux_scan_nw.sv - registered N-channel W-bit multiplexer with manual and auto-scan select
//
// Ports:
//   CLK    in   1       system clock, all state changes on the rising edge
//   RST_N  in   1       asynchronous active-low reset
//   D      in   N*W     flat input bus, channel k at D[k*W +: W]
//   SEL    in   SELW    manual channel select (out-of-range clamps to N-1)
//   MODE   in   1       0 = manual, 1 = auto-scan
//   EN     in   1       clock enable, 0 freezes all state
//   Y      out  W       registered data of the selected channel
//   CH     out  SELW    registered index of the channel driving Y
//   NEW    out  1       one-cycle pulse in the first cycle CH shows a new value

module mux_scan_nw #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int DWELL = 16,
  parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N*W-1:0]    D,
  input  logic [SELW-1:0]   SEL,
  input  logic              MODE,
  input  logic              EN,
  output logic [W-1:0]      Y,
  output logic [SELW-1:0]   CH,
  output logic              NEW
);

  localparam logic [SELW-1:0] LAST_CH  = SELW'(N - 1);
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  // One extra bit so the comparison against N stays exact when N is a power of two.
  localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);

  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] nch;
  logic [SELW-1:0] sel_clamp;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            mode_q;
  logic [W-1:0]    ysel;
  logic [W-1:0]    chan [N];

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_chan
      assign chan[k] = D[k*W +: W];
    end
  endgenerate

  // Out-of-range selects fall back to the last channel.
  assign sel_clamp = ({1'b0, SEL} < N_EXT) ? SEL : LAST_CH;

  // Next channel and dwell count. Entering scan keeps the current channel and
  // restarts the dwell, so the first scan dwell is a full DWELL cycles long.
  always_comb begin
    nch   = ch_q;
    cnt_d = cnt_q;
    if (EN) begin
      if (!MODE) begin
        nch   = sel_clamp;
        cnt_d = '0;
      end else if (!mode_q) begin
        nch   = ch_q;
        cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
        nch   = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        cnt_d = '0;
      end else begin
        nch   = ch_q;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Data selected by the next channel, so Y follows live data of nch.
  always_comb begin
    ysel = chan[0];
    for (int i = 1; i < N; i++) begin
      if (nch == SELW'(i)) begin
        ysel = chan[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ch_q   <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      Y      <= '0;
      NEW    <= 1'b0;
    end else if (EN) begin
      ch_q   <= nch;
      cnt_q  <= cnt_d;
      mode_q <= MODE;
      Y      <= ysel;
      NEW    <= (nch != ch_q);
    end else begin
      NEW    <= 1'b0;
    end
  end

  assign CH = ch_q;

endmodule

// File: tb/tb_mux_scan_nw.sv
// tb/tb_mux_scan_nw.sv - scoreboard bench for mux_scan_nw

module tb_mux_scan_nw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: W=8, N=4, DWELL=3
  logic [31:0] d_a = 32'hDDCCBBAA;
  logic [1:0]  sel_a = '0;
  logic        mode_a = 1'b0, en_a = 1'b0;
  logic [7:0]  y_a;
  logic [1:0]  ch_a;
  logic        new_a;

  // DUT B: W=8, N=3, DWELL=2
  logic [23:0] d_b = 24'h322110;
  logic [1:0]  sel_b = '0;
  logic        mode_b = 1'b0, en_b = 1'b0;
  logic [7:0]  y_b;
  logic [1:0]  ch_b;
  logic        new_b;

  // DUT C: W=8, N=5, DWELL=1
  logic [39:0] d_c = 40'h4443424140;
  logic [2:0]  sel_c = '0;
  logic        mode_c = 1'b0, en_c = 1'b0;
  logic [7:0]  y_c;
  logic [2:0]  ch_c;
  logic        new_c;

  mux_scan_nw #(.W(8), .N(4), .DWELL(3)) u_a (
    .CLK(clk), .RST_N(rst_n), .D(d_a), .SEL(sel_a), .MODE(mode_a), .EN(en_a),
    .Y(y_a), .CH(ch_a), .NEW(new_a));

  mux_scan_nw #(.W(8), .N(3), .DWELL(2)) u_b (
    .CLK(clk), .RST_N(rst_n), .D(d_b), .SEL(sel_b), .MODE(mode_b), .EN(en_b),
    .Y(y_b), .CH(ch_b), .NEW(new_b));

  mux_scan_nw #(.W(8), .N(5), .DWELL(1)) u_c (
    .CLK(clk), .RST_N(rst_n), .D(d_c), .SEL(sel_c), .MODE(mode_c), .EN(en_c),
    .Y(y_c), .CH(ch_c), .NEW(new_c));

  typedef struct {
    int         dut;
    int         ch;
    logic [7:0] y;
    logic       nw;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [39:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  task automatic sb_push(input int dut, input int ch, input logic [7:0] y,
                         input logic nw, input string nm);
    exp_t e;
    e.dut = dut; e.ch = ch; e.y = y; e.nw = nw; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle; compare one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int   ach, ay, an;
      e = sb.pop_front();
      case (e.dut)
        0:       begin ach = int'(ch_a); ay = int'(y_a); an = int'(new_a); end
        1:       begin ach = int'(ch_b); ay = int'(y_b); an = int'(new_b); end
        default: begin ach = int'(ch_c); ay = int'(y_c); an = int'(new_c); end
      endcase
      chk({e.nm, ".ch"},  ach, e.ch);
      chk({e.nm, ".y"},   ay,  int'(e.y));
      chk({e.nm, ".new"}, an,  int'(e.nw));
    end
  end

  int seq_a [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int seq_f [6]  = '{0, 1, 1, 1, 2, 2};
  int new_f [6]  = '{0, 1, 0, 0, 1, 0};
  int seq_r [4]  = '{0, 0, 0, 1};
  int seq_c [6]  = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // N=3 manual select with out-of-range clamp
    en_b = 1'b1; mode_b = 1'b0;
    sel_b = 2'd3; sb_push(1, 2, 8'h32, 1'b1, "clamp_b");   tick();
    sel_b = 2'd1; sb_push(1, 1, 8'h21, 1'b1, "sel1_b");    tick();
    sel_b = 2'd1; sb_push(1, 1, 8'h21, 1'b0, "resel_b");   tick();
    sel_b = 2'd3; sb_push(1, 2, 8'h32, 1'b1, "clamp2_b");  tick();
    en_b = 1'b0;

    // N=5, DWELL=1 scan wrap, then switch to manual
    en_c = 1'b1; mode_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb_push(2, seq_c[i], byte_of(d_c, seq_c[i]), (i > 0), "scan_c");
      tick();
    end
    mode_c = 1'b0; sel_c = 3'd1;
    sb_push(2, 1, 8'h41, 1'b1, "man_c");   tick();
    sel_c = 3'd7;
    sb_push(2, 4, 8'h44, 1'b1, "clamp_c"); tick();
    en_c = 1'b0;

    // N=4 manual select then asynchronous reset
    en_a = 1'b1; mode_a = 1'b0; sel_a = 2'd2;
    sb_push(0, 2, 8'hCC, 1'b1, "man_a");   tick();
    sb_push(0, 2, 8'hCC, 1'b0, "hold_a");  tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async.y",   int'(y_a),   0);
    chk("rst_async.ch",  int'(ch_a),  0);
    chk("rst_async.new", int'(new_a), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Scan rotation with a live data change on channel 1
    mode_a = 1'b1; sel_a = 2'd0;
    for (int i = 0; i < 13; i++) begin
      if (i == 4) d_a[15:8] = 8'h5B;
      if (i == 6) d_a[15:8] = 8'hBB;
      sb_push(0, seq_a[i], byte_of(d_a, seq_a[i]),
              (i > 0 && seq_a[i] != seq_a[i-1]), "scan_a");
      tick();
    end

    // Enable freeze mid-dwell; Y must hold even though channel 0 data moves
    sb_push(0, 0, 8'hAA, 1'b0, "pre_frz"); tick();
    en_a = 1'b0; d_a[7:0] = 8'h11;
    for (int i = 0; i < 5; i++) begin
      sb_push(0, 0, 8'hAA, 1'b0, "frz_a");
      tick();
    end
    d_a[7:0] = 8'hAA; en_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb_push(0, seq_f[i], byte_of(d_a, seq_f[i]), new_f[i] != 0, "post_frz");
      tick();
    end

    // Reset mid-scan (CH=2, count=1), then restart on channel 0
    #2 rst_n = 1'b0;
    #1;
    chk("rst_scan.y",   int'(y_a),   0);
    chk("rst_scan.ch",  int'(ch_a),  0);
    chk("rst_scan.new", int'(new_a), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_push(0, seq_r[i], byte_of(d_a, seq_r[i]), (i == 3), "rst_rescan");
      tick();
    end

    // Scan to manual: SEL takes effect on the first MODE=0 edge
    mode_a = 1'b0; sel_a = 2'd3;
    sb_push(0, 3, 8'hDD, 1'b1, "to_man_a");  tick();
    sb_push(0, 3, 8'hDD, 1'b0, "man_hold");  tick();

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_nw.md
# mux_scan_nw

Registered, parametrised N-channel, W-bit multiplexer with manual and auto-scan selection. In manual mode it routes the channel chosen by `SEL`. In scan mode an internal dwell counter steps through the channels round-robin. It replaces the fixed 4:1 single-bit selector wherever a datapath needs wider words, more channels, a registered output, or time-multiplexed display/acquisition scanning.

## Interface
Parameters:
- `W`, 8, data width per channel (≥1)
- `N`, 4, channel count (≥2)
- `SELW`, `$clog2(N)`, select/channel-index width (derived; do not override)
- `DWELL`, 16, cycles spent on each channel in scan mode (≥1)
- `CW`, `$clog2(DWELL)` (min 1), dwell-counter width (derived)

Ports:
- `CLK`  in  1  system clock; all state changes on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `D`  in  N*W  flat input bus; channel k occupies `D[k*W +: W]`
- `SEL`  in  SELW  manual channel select
- `MODE`  in  1  0 = manual, 1 = auto-scan
- `EN`  in  1  clock enable; 0 freezes all state
- `Y`  out  W  registered selected data
- `CH`  out  SELW  registered index of the channel currently driving `Y`
- `NEW`  out  1  one-cycle pulse, high in the first cycle `CH` shows a new value

Decided: one clock; reset is asynchronous and active-low.

## Operation
- Internal state consists of `ch_q` (drives `CH`), `cnt_q` (dwell counter, CW bits), `mode_q` (previous `MODE`), `Y`, and `NEW`.
- Next channel `nch`:
  - When `EN`=0: `nch = ch_q`.
  - Manual mode (`MODE`=0): `nch = SEL` if `SEL < N`, else `N-1`. The out-of-range select clamps to the last channel, matching the old block's default branch.
  - Scan mode (`MODE`=1):
    - If `mode_q`=0 (entering scan this cycle): `nch = ch_q`, and `cnt_q` clears to 0.
    - Else if `cnt_q == DWELL-1`: `nch = (ch_q == N-1) ? 0 : ch_q+1`, and `cnt_q` clears to 0.
    - Else: `nch = ch_q`, and `cnt_q` increments.
- Update on each edge with `EN`=1:
  - `ch_q <= nch`.
  - `Y <= D[nch*W +: W]`, so `Y` always tracks the live data of `nch`.
  - `NEW <= (nch != ch_q)`.
  - `mode_q <= MODE`.
- In manual mode `cnt_q` is held at 0.
- `EN`=0: `ch_q`, `cnt_q`, `mode_q` and `Y` all hold, and `NEW` is forced to 0.
- `DWELL`=1: the channel advances every enabled cycle in scan mode, and `NEW` stays high continuously.
- `N` not a power of two: the scan wrap occurs at N-1, never at 2^SELW-1.

## Timing
- Reset (`RST_N`=0, asynchronous, immediate): `Y`=0, `CH`=0, `NEW`=0, `cnt_q`=0, `mode_q`=0. Normal operation resumes on the first rising edge after release.
- Latency from `SEL` to `CH`/`Y`: 1 cycle. Latency from a `D` change on the selected channel to `Y`: 1 cycle. There is no combinational path from inputs to outputs.
- Scan period: each channel holds for exactly `DWELL` enabled cycles. A full rotation takes N·DWELL enabled cycles. `EN`-low cycles stretch the period and are not counted.
- Mode switches:
  - Manual→scan: the first scan dwell starts on the current channel and lasts `DWELL` cycles.
  - Scan→manual: `SEL` takes effect on the same edge at which `MODE`=0 is sampled.
- `NEW` is registered and coincides with the first cycle of the new `CH`/`Y`. It never asserts when the channel is unchanged, including when the same channel is re-selected in manual mode.
- Reset asserted mid-scan: all outputs return immediately to their reset values. After release in scan mode, the first dwell starts on channel 0 and `cnt_q` starts from 0.

## Test plan
- **Reset values:** assert `RST_N`=0 asynchronously mid-cycle with `D` non-zero → `Y`=0, `CH`=0, `NEW`=0 immediately, without waiting for a clock edge.
- **Manual select and clamp:** W=8, N=4, `D`={8'hDD,8'hCC,8'hBB,8'hAA}, `SEL`=2 → next cycle `Y`=8'hCC, `CH`=2, `NEW`=1, and `NEW` is 0 on the following cycle. With N=3, `SEL`=3 → `CH`=2 (clamped).
- **Scan rotation:** N=4, `DWELL`=3, `MODE`=1 from `CH`=0 →
  - `CH` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
  - `NEW` high only in the first cycle of each new channel.
  - `Y` tracks each channel's live data.
- **Enable freeze:** during scan, hold `EN`=0 for 5 cycles mid-dwell → `CH`, `Y` and `cnt_q` are unchanged and `NEW`=0. After `EN` returns to 1, the remaining dwell cycles complete exactly as before the freeze.
- **Mode switch and non-power-of-two wrap:** N=5, `DWELL`=1, scan → `CH` sequence 0,1,2,3,4,0. Then drive `MODE`=0 with `SEL`=1 → next cycle `CH`=1, `NEW`=1.
- **Reset mid-scan:** assert `RST_N` low while `CH`=2 and `cnt_q`=1, then release with `MODE`=1 → dwell restarts on channel 0 and lasts the full `DWELL` cycles.
